// File: rtl/delay_pkg.sv
// Shared encodings and Q15 constants for the delay-line LFO.
package delay_pkg;

    typedef enum logic [1:0] {
        WAVE_TRI = 2'b00,
        WAVE_SQR = 2'b01,
        WAVE_SAW = 2'b10,
        WAVE_OFF = 2'b11
    } wave_e;

    localparam logic signed [15:0] Q15_MAX   = 16'sd32767;
    localparam logic signed [15:0] Q15_ROUND = 16'sd16384;

    localparam int LFO_PHASE_W = 24;
    localparam int LFO_OUT_W   = 16;
    localparam int LFO_DEPTH_W = 8;

endpackage

// File: rtl/delay_lfo_if.sv
// LFO control/output bundle. Valid-only stream: mod_valid qualifies mod_val and
// cycle_pulse for exactly one clk; there is no backpressure, the consumer must take it.
interface delay_lfo_if #(
    parameter int PHASE_W = 24,
    parameter int DEPTH_W = 8,
    parameter int OUT_W   = 16
);
    logic                      en;
    logic                      sync;
    logic [PHASE_W-1:0]        rate;
    logic [DEPTH_W-1:0]        depth;
    logic [1:0]                wave_sel;
    logic signed [OUT_W-1:0]   mod_val;
    logic                      mod_valid;
    logic                      cycle_pulse;

    modport master (
        output en, sync, rate, depth, wave_sel,
        input  mod_val, mod_valid, cycle_pulse
    );

    modport slave (
        input  en, sync, rate, depth, wave_sel,
        output mod_val, mod_valid, cycle_pulse
    );
endinterface

// File: rtl/delay_lfo_shaper.sv
// Stage 2: maps the top 16 phase bits to a Q15 waveform and carries the
// valid/wrap bits alongside so they stay aligned with the shaped value.
module delay_lfo_shaper
    import delay_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               v1_i,
    input  logic               w1_i,
    input  logic [15:0]        u_i,
    input  wave_e              wave_sel_i,
    output logic               v2_o,
    output logic               w2_o,
    output logic signed [15:0] shape_o
);
    logic [14:0]        fold;
    logic signed [16:0] tri_w;
    logic [15:0]        saw;
    logic signed [15:0] shape_d;
    logic signed [15:0] shape_q;
    logic               v2_q;
    logic               w2_q;

    always_comb begin
        fold    = u_i[15] ? ~u_i[14:0] : u_i[14:0];
        tri_w   = $signed({1'b0, fold, 1'b0}) - 17'sd32767;
        saw     = {~u_i[15], u_i[14:0]};
        shape_d = '0;
        case (wave_sel_i)
            WAVE_TRI: shape_d = tri_w[15:0];
            WAVE_SQR: shape_d = u_i[15] ? -Q15_MAX : Q15_MAX;
            // -32768 is pulled in by one LSB so the saw swings symmetrically
            WAVE_SAW: shape_d = (saw == 16'h8000) ? -Q15_MAX : $signed(saw);
            WAVE_OFF: shape_d = '0;
            default:  shape_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            w2_q    <= 1'b0;
            shape_q <= '0;
        end else begin
            v2_q <= v1_i;
            w2_q <= w1_i;
            if (v1_i) begin
                shape_q <= shape_d;
            end
        end
    end

    assign v2_o    = v2_q;
    assign w2_o    = w2_q;
    assign shape_o = shape_q;
endmodule

// File: rtl/delay_lfo.sv
// Modulation LFO for delay_core: phase accumulator, waveform shaper and
// depth scaling, producing one registered signed mod_val per sample strobe.
module delay_lfo
    import delay_pkg::*;
#(
    parameter int PHASE_W = LFO_PHASE_W,
    parameter int OUT_W   = LFO_OUT_W,
    parameter int DEPTH_W = LFO_DEPTH_W
) (
    input  logic        clk,
    input  logic        rst_n,
    delay_lfo_if.slave  bus
);
    localparam int PROD_W = 16 + DEPTH_W + 2;

    logic [PHASE_W-1:0] phase_d, phase_q;
    logic [PHASE_W:0]   sum_ext;
    logic               v1_q, w1_q;
    logic               v2, w2;
    logic signed [15:0] shape;

    logic signed [PROD_W-1:0] shape_ext, depth_ext, prod, rounded, scaled;
    logic signed [OUT_W-1:0]  mod_val_d, mod_val_q;
    logic                     mod_valid_q, cycle_pulse_q;

    // Stage 1: phase accumulator; the adder carry marks a completed LFO period
    always_comb begin
        sum_ext = {1'b0, phase_q} + {1'b0, bus.rate};
        phase_d = phase_q;
        if (bus.sync) begin
            phase_d = '0;
        end else if (bus.en) begin
            phase_d = sum_ext[PHASE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            v1_q    <= 1'b0;
            w1_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            v1_q    <= bus.en;
            w1_q    <= bus.sync | sum_ext[PHASE_W];
        end
    end

    delay_lfo_shaper u_shaper (
        .clk        (clk),
        .rst_n      (rst_n),
        .v1_i       (v1_q),
        .w1_i       (w1_q),
        .u_i        (phase_q[PHASE_W-1 -: 16]),
        .wave_sel_i (wave_e'(bus.wave_sel)),
        .v2_o       (v2),
        .w2_o       (w2),
        .shape_o    (shape)
    );

    // Stage 3: Q15 x depth, round half up, back to whole samples
    always_comb begin
        shape_ext = PROD_W'(shape);
        depth_ext = PROD_W'(bus.depth);
        prod      = shape_ext * depth_ext;
        rounded   = prod + PROD_W'(Q15_ROUND);
        scaled    = rounded >>> 15;
        mod_val_d = scaled[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_val_q     <= '0;
            mod_valid_q   <= 1'b0;
            cycle_pulse_q <= 1'b0;
        end else begin
            mod_valid_q   <= v2;
            cycle_pulse_q <= v2 & w2;
            if (v2) begin
                mod_val_q <= mod_val_d;
            end
        end
    end

    assign bus.mod_val     = mod_val_q;
    assign bus.mod_valid   = mod_valid_q;
    assign bus.cycle_pulse = cycle_pulse_q;
endmodule

// File: tb/tb_delay_lfo.sv
// Directed bench for delay_lfo: drivers push hand-computed samples into a
// queue, a negedge monitor pops and checks value, period flag and arrival cycle.
module tb_delay_lfo;
    import delay_pkg::*;

    localparam int PW = 24;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int EW = 32 + 1 + OW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [EW-1:0]          exp_q[$];
    logic [EW-1:0]          mon_e;
    logic signed [OW-1:0]   held = '0;

    int tri_tab[16] = '{-255, -191, -127, -64, 0, 64, 128, 191,
                        255, 191, 127, 64, 0, -64, -128, -191};

    delay_lfo_if #(.PHASE_W(PW), .DEPTH_W(DW), .OUT_W(OW)) lfo_if ();

    delay_lfo #(.PHASE_W(PW), .OUT_W(OW), .DEPTH_W(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lfo_if.slave)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held = '0;
        end else if (lfo_if.mod_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got mod_val=%0d, expected no output (cycle %0d)",
                         lfo_if.mod_val, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("mod_val", int'(lfo_if.mod_val), int'($signed(mon_e[OW-1:0])));
                check("cycle_pulse", int'(lfo_if.cycle_pulse), int'(mon_e[OW]));
                check("latency_cycle", cyc, int'(mon_e[EW-1:OW+1]));
                held = mon_e[OW-1:0];
            end
        end else begin
            check("mod_val_hold", int'(lfo_if.mod_val), int'(held));
            check("cycle_pulse_idle", int'(lfo_if.cycle_pulse), 0);
        end
    end

    // driver tasks
    task automatic set_cfg(input logic [1:0] ws, input int dp, input logic [PW-1:0] rt);
        lfo_if.wave_sel = ws;
        lfo_if.depth    = dp[DW-1:0];
        lfo_if.rate     = rt;
    endtask

    task automatic sample(input logic s, input int v, input logic cp);
        logic [31:0] due;
        @(posedge clk);
        #1;
        lfo_if.en   = 1'b1;
        lfo_if.sync = s;
        due = 32'(cyc + 3);
        exp_q.push_back({due, cp, v[OW-1:0]});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            lfo_if.en   = 1'b0;
            lfo_if.sync = 1'b0;
        end
    endtask

    task automatic sync_only();
        @(posedge clk);
        #1;
        lfo_if.en   = 1'b0;
        lfo_if.sync = 1'b1;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lfo_if.en       = 1'b0;
        lfo_if.sync     = 1'b0;
        lfo_if.rate     = '0;
        lfo_if.depth    = '0;
        lfo_if.wave_sel = WAVE_TRI;

        // reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            lfo_if.en       = ~lfo_if.en;
            lfo_if.sync     = ~lfo_if.sync;
            lfo_if.rate     = 24'h123456 + 24'(i);
            lfo_if.depth    = 8'hff;
            lfo_if.wave_sel = 2'(i);
            check("reset_mod_val", int'(lfo_if.mod_val), 0);
            check("reset_mod_valid", int'(lfo_if.mod_valid), 0);
            check("reset_cycle_pulse", int'(lfo_if.cycle_pulse), 0);
        end
        lfo_if.en   = 1'b0;
        lfo_if.sync = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // triangle, full depth, 16-sample period
        set_cfg(WAVE_TRI, 255, 24'h100000);
        sample(1'b1, tri_tab[0], 1'b1);
        for (int k = 1; k < 16; k++) sample(1'b0, tri_tab[k], 1'b0);
        sample(1'b0, -255, 1'b1);
        idle(4);

        // square
        set_cfg(WAVE_SQR, 100, 24'h100000);
        sample(1'b1, 100, 1'b1);
        for (int k = 1; k < 8; k++) sample(1'b0, 100, 1'b0);
        for (int k = 8; k < 16; k++) sample(1'b0, -100, 1'b0);
        idle(4);

        // saw extremes, then off and zero depth
        set_cfg(WAVE_SAW, 128, 24'hFFFF00);
        sample(1'b1, -128, 1'b1);
        sample(1'b0, 128, 1'b0);
        idle(4);
        set_cfg(WAVE_OFF, 128, 24'hFFFF00);
        sample(1'b0, 0, 1'b1);
        idle(4);
        set_cfg(WAVE_SAW, 0, 24'hFFFF00);
        sample(1'b0, 0, 1'b1);
        idle(4);

        // sparse strobes and sync without en
        set_cfg(WAVE_TRI, 255, 24'h100000);
        sync_only();
        idle(3);
        sample(1'b0, -191, 1'b0); idle(3);
        sample(1'b0, -127, 1'b0); idle(3);
        sample(1'b0, -64, 1'b0);  idle(3);
        sample(1'b0, 0, 1'b0);    idle(3);
        sync_only();
        idle(3);
        sample(1'b0, -191, 1'b0);
        idle(4);

        // async reset between edges discards an in-flight sample
        @(posedge clk);
        #1;
        lfo_if.en = 1'b1;
        @(posedge clk);
        #1;
        lfo_if.en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_mod_val", int'(lfo_if.mod_val), 0);
        check("async_reset_mod_valid", int'(lfo_if.mod_valid), 0);
        check("async_reset_cycle_pulse", int'(lfo_if.cycle_pulse), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(3);
        sample(1'b0, -191, 1'b0);
        idle(4);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/delay_lfo.md
Name: delay_lfo

Overview:
Low-frequency oscillator that generates the signed modulation value feeding delay_core's mod_val port, for vibrato, chorus and flanger effects. A phase accumulator advances once per audio sample strobe. Its phase is shaped into a triangle, square or saw waveform and scaled by a depth in samples. The output is registered and valid-flagged, and holds between samples.

Parameters:
PHASE_W, 24, phase accumulator width; LFO frequency = rate / 2^PHASE_W × sample rate
OUT_W, 16, mod_val width; signed, matches delay_core mod_val
DEPTH_W, 8, depth width; peak excursion in samples, max 2^DEPTH_W − 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  sample strobe; one pulse per audio sample
sync  in  1  phase reset request, sampled on clk
rate  in  PHASE_W  unsigned phase increment per sample
depth  in  DEPTH_W  unsigned peak modulation in samples
wave_sel  in  2  00 triangle, 01 square, 10 saw-up, 11 off (zero)
mod_val  out  OUT_W  signed modulation; drives delay_core mod_val
mod_valid  out  1  one-cycle pulse when mod_val updates
cycle_pulse  out  1  one-cycle pulse, coincident with mod_valid, marking the first sample of a new LFO period

Behaviour:
- Reset (async, rst_n=0):
  - phase_q, pipeline registers, mod_val, mod_valid and cycle_pulse all clear to 0 immediately.
  - Reset asserted mid-operation discards in-flight samples.
- Stage 1 (phase), evaluated at each clk edge:
  - sync=1: phase_q <= 0. sync has priority over the advance.
  - else en=1: phase_q <= phase_q + rate, modulo 2^PHASE_W.
  - v1 <= en. w1 <= sync OR carry-out of the addition (wrap flag).
  - sync=1 with en=0: phase clears, no output update.
  - rate=0: phase frozen; output stays constant at each strobe.
- Stage 2 (shaper), loads when v1=1:
  - u = phase_q[PHASE_W−1 -: 16], unsigned.
  - Triangle: f = u[15] ? ~u[14:0] : u[14:0]; w = 2f − 32767. Range −32767..+32767.
  - Square: w = u[15] ? −32767 : +32767.
  - Saw: w = {~u[15], u[14:0]} as signed; −32768 clamps to −32767.
  - Off: w = 0.
  - wave_sel is sampled here; v2 <= v1; w2 <= w1.
- Stage 3 (scale), loads when v2=1:
  - p = w × depth (depth zero-extended; 26-bit signed product).
  - mod_val <= (p + 16384) >>> 15. Arithmetic shift, round-half-up.
  - Result is symmetric: ±depth at waveform peaks; |mod_val| ≤ 255 fits OUT_W.
  - depth is sampled here.
- Outputs:
  - mod_valid <= v2 and cycle_pulse <= v2 & w2, one cycle each. mod_val holds otherwise.
  - Latency: en sampled at edge k → mod_val/mod_valid change at edge k+2.
  - Back-to-back en every cycle is supported at full throughput.
- rate/depth/wave_sel changes take effect at the next sample in which they are sampled; no glitch-smoothing.

Decomposition:
- Package delay_pkg:
  - wave_sel encodings WAVE_TRI, WAVE_SQR, WAVE_SAW, WAVE_OFF.
  - Q15 constants Q15_MAX=32767, Q15_ROUND=16384.
  - OUT_W default 16.
- Sub-module delay_lfo_shaper: stage-2 register holding phase-to-waveform mapping plus saw clamp, with its valid/wrap pipeline bits.
- Top contains the accumulator and scaling stage.

Test Plan:
1. Reset: hold rst_n=0, toggle inputs → mod_val=0, mod_valid=0, cycle_pulse=0. Deassert, no en → outputs stay 0.
2. Triangle, rate=0x100000, depth=255, en every cycle, sync with first en:
   - first mod_val=−255 with cycle_pulse=1;
   - 8th sample (u=0x8000) = +255;
   - 16th sample returns to −255 with cycle_pulse=1;
   - period = 16 samples.
3. Square, depth=100, rate=0x100000 → mod_val alternates +100 for 8 samples, −100 for 8 samples.
4. Saw, depth=128: phase u=0 → −128; u=0xFFFF (rate=0xFFFF00 after sync) → +128. wave_sel=11 or depth=0 → mod_val=0 with mod_valid still pulsing.
5. Sparse en (one pulse every 4 cycles) → mod_valid exactly 2 cycles after each en edge; mod_val stable between; sync with en=0 → no mod_valid.
6. Async reset asserted mid-run between edges → outputs clear immediately. After release, first en with rate=R, depth=255 triangle → mod_val from phase R (R=0x100000 → −191).
